// File: rtl/alu_issue_sequencer_if.sv
// Handshake bundle between the instruction source / result consumer and
// the ALU issue sequencer: instruction valid/ready in, result valid/ready out.
interface alu_issue_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W+7:0] instr_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic              res_neg;

  // Upstream producer / downstream consumer side.
  modport master (
    output instr_valid, instr_data, res_ready,
    input  instr_ready, res_valid, res_data, res_zero, res_neg
  );

  // Sequencer side.
  modport slave (
    input  instr_valid, instr_data, res_ready,
    output instr_ready, res_valid, res_data, res_zero, res_neg
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Issue sequencer for an external combinational ALU. Holds a 4-entry
// register file, issues registered operands/opcode, writes the ALU result
// back one cycle later and presents it on a valid/ready result port.
// Load-immediate instructions write the register file directly.
module alu_issue_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_sequencer_if.slave    bus,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [2:0]              alu_op,
  input  logic [DATA_W-1:0]       alu_out,
  input  logic [1:0]              dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Instruction field decode.
  logic              f_is_load;
  logic [2:0]        f_opcode;
  logic [1:0]        f_dst;
  logic [1:0]        f_src_a;
  logic [1:0]        f_src_b;
  logic [DATA_W-1:0] f_imm;

  assign f_is_load = bus.instr_data[DATA_W+7];
  assign f_opcode  = bus.instr_data[DATA_W+6:DATA_W+4];
  assign f_dst     = bus.instr_data[DATA_W+3:DATA_W+2];
  assign f_src_a   = bus.instr_data[DATA_W+1:DATA_W];
  assign f_src_b   = bus.instr_data[DATA_W-1:DATA_W-2];
  assign f_imm     = bus.instr_data[DATA_W-1:0];

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic [DATA_W-1:0] alu_a_q,     alu_a_d;
  logic [DATA_W-1:0] alu_b_q,     alu_b_d;
  logic [2:0]        alu_op_q,    alu_op_d;
  logic [1:0]        dst_q,       dst_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic              res_valid_q, res_valid_d;

  logic              instr_ready;

  // Ready only in IDLE and forced low while reset is held, so nothing is
  // taken during reset and the first post-reset cycle can accept.
  assign instr_ready = rst_n && (state_q == IDLE);

  // Next-state, register-file write and operand/result latching.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    dst_d       = dst_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid && instr_ready) begin
          if (f_is_load) begin
            regs_d[f_dst] = f_imm;
          end else begin
            // Operands are read at accept, so src == dst sees the old value.
            alu_a_d  = regs_q[f_src_a];
            alu_b_d  = regs_q[f_src_b];
            alu_op_d = f_opcode;
            dst_d    = f_dst;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        // ALU has had a full cycle on the registered operands.
        regs_d[dst_q] = alu_out;
        res_data_d    = alu_out;
        res_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State, register file and datapath registers.
  // NOTE: the register file is small and architecturally defined to read
  // zero after reset, so it is reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      dst_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;
  assign bus.instr_ready = instr_ready;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  // Flags come from the registered result so they stay stable under backpressure.
  assign bus.res_zero   = (res_data_q == '0);
  assign bus.res_neg    = res_data_q[DATA_W-1];
  assign dbg_data       = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer: directed scenarios followed
// by randomized loads / ALU ops / backpressure against a register-file model.
module tb_alu_issue_sequencer;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic [1:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  alu_issue_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_issue_sequencer #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU; also used by the model to predict results.
  function automatic logic [7:0] alu_ref(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op, alu_a, alu_b);

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_regs [4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reg(input logic [1:0] idx);
    dbg_addr = idx;
    #1;
    check($sformatf("r%0d", idx), dbg_data, m_regs[idx]);
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 4; i++) check_reg(2'(i));
  endtask

  // Issue one load; assumes sequencer is idle at call time.
  task automatic do_load(input logic [1:0] dst, input logic [7:0] imm);
    check("ld_ready", bus.instr_ready, 1);
    check("ld_no_res", bus.res_valid, 0);
    bus.instr_valid = 1'b1;
    bus.instr_data  = {1'b1, 3'b000, dst, 2'b00, imm};
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    m_regs[dst] = imm;
  endtask

  // Issue one ALU instruction, optionally stall the result for `stall`
  // cycles while offering a load that must not be taken early.
  task automatic do_alu(input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] sa, input logic [1:0] sb,
                        input int stall, input bit offer);
    logic [7:0] a, b, exp, ld_imm;
    logic [1:0] ld_dst;
    a   = m_regs[sa];
    b   = m_regs[sb];
    exp = alu_ref(op, a, b);
    ld_dst = 2'($urandom_range(0, 3));
    ld_imm = 8'($urandom);
    check("acc_ready", bus.instr_ready, 1);
    bus.res_ready   = (stall == 0);
    bus.instr_valid = 1'b1;
    bus.instr_data  = {1'b0, op, dst, sa, sb, 6'($urandom)};
    @(posedge clk); #1;                     // accept edge
    bus.instr_valid = 1'b0;
    check("exec_a", alu_a, a);
    check("exec_b", alu_b, b);
    check("exec_op", alu_op, op);
    check("exec_ready", bus.instr_ready, 0);
    check("exec_valid", bus.res_valid, 0);
    @(posedge clk); #1;                     // write-back edge
    m_regs[dst] = exp;
    check("res_valid", bus.res_valid, 1);
    check("res_data", bus.res_data, exp);
    check("res_zero", bus.res_zero, exp == 8'h00);
    check("res_neg", bus.res_neg, exp[7]);
    check("resp_ready", bus.instr_ready, 0);
    if (stall > 0) begin
      if (offer) begin
        bus.instr_valid = 1'b1;
        bus.instr_data  = {1'b1, 3'b000, ld_dst, 2'b00, ld_imm};
      end
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_valid", bus.res_valid, 1);
        check("stall_data", bus.res_data, exp);
        check("stall_ready", bus.instr_ready, 0);
        check("stall_hold_a", alu_a, a);
        if (offer) check_reg(ld_dst);
      end
      bus.res_ready = 1'b1;
    end
    @(posedge clk); #1;                     // result handshake edge
    check("done_valid", bus.res_valid, 0);
    check("done_ready", bus.instr_ready, 1);
    if (stall > 0 && offer) begin
      check_reg(ld_dst);                    // still not written
      @(posedge clk); #1;                   // load accepted here
      bus.instr_valid = 1'b0;
      m_regs[ld_dst] = ld_imm;
      check_reg(ld_dst);
    end
    check_reg(dst);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.res_ready   = 1'b1;
    dbg_addr        = 2'd0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.instr_ready, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check_all_regs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.instr_ready, 1);
    @(posedge clk); #1;

    // Back-to-back loads.
    do_load(2'd0, 8'h3C);
    do_load(2'd1, 8'h0F);
    check("ld_ready_after", bus.instr_ready, 1);
    check_all_regs();

    // ADD r2 = r0 + r1 with fixed expectations.
    do_alu(3'd0, 2'd2, 2'd0, 2'd1, 0, 1'b0);
    dbg_addr = 2'd2; #1;
    check("add_r2_const", dbg_data, 8'h4B);
    // SUB r3 = r1 - r0 -> 0xD3, negative.
    do_alu(3'd1, 2'd3, 2'd1, 2'd0, 0, 1'b0);
    dbg_addr = 2'd3; #1;
    check("sub_r3_const", dbg_data, 8'hD3);
    // XOR r0 = r0 ^ r0 -> zero.
    do_alu(3'd4, 2'd0, 2'd0, 2'd0, 0, 1'b0);
    dbg_addr = 2'd0; #1;
    check("xor_r0_const", dbg_data, 8'h00);

    // Backpressure: 5 stall cycles with an offered load.
    do_alu(3'd0, 2'd2, 2'd2, 2'd3, 5, 1'b1);

    // SHL with dst == src_a: old operand used.
    do_load(2'd1, 8'h81);
    do_alu(3'd6, 2'd1, 2'd1, 2'd1, 0, 1'b0);
    dbg_addr = 2'd1; #1;
    check("shl_r1_const", dbg_data, 8'h02);

    // Randomized mix.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_load(2'($urandom_range(0, 3)), 8'($urandom));
      else
        do_alu(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (n % 25 == 0) check_all_regs();
    end

    // Reset during EXEC of ADD to r2: write-back must be lost.
    check("pre_rst_ready", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr_data  = {1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 6'd0};
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    check("exec_before_rst", bus.instr_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.instr_ready, 0);
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_alu_a", alu_a, 0);
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", bus.instr_ready, 1);
    check("rel_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    check("rel_valid_next", bus.res_valid, 0);
    check_all_regs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
